// File: rtl/hcsr04_scheduler_if.sv
// hcsr04_scheduler_if: run/enable control, shared ranging-engine link, sensor lines and result port.
interface hcsr04_scheduler_if #(parameter int N_SENS = 4);
    localparam int SW = $clog2(N_SENS);
    logic              run;
    logic [N_SENS-1:0] en_mask;
    logic              eng_start;
    logic              eng_rst_n;
    logic              eng_trig;
    logic              eng_echo;
    logic              eng_val;
    logic [11:0]       eng_distance;
    logic [N_SENS-1:0] trig_out;
    logic [N_SENS-1:0] echo_in;
    logic [SW-1:0]     sel;
    logic              busy;
    logic              res_valid;
    logic [SW-1:0]     res_id;
    logic [11:0]       res_dist;
    logic              res_err;
    modport slave (
        input  run, en_mask, eng_trig, eng_val, eng_distance, echo_in,
        output eng_start, eng_rst_n, eng_echo, trig_out, sel, busy,
               res_valid, res_id, res_dist, res_err
    );
    modport master (
        output run, en_mask, eng_trig, eng_val, eng_distance, echo_in,
        input  eng_start, eng_rst_n, eng_echo, trig_out, sel, busy,
               res_valid, res_id, res_dist, res_err
    );
endinterface

// File: rtl/hcsr04_scheduler.sv
// hcsr04_scheduler: round-robin sharing of one HC-SR04 ranging engine among N sensors,
// with timeout recovery, fixed start-to-start spacing and tagged result strobes.
module hcsr04_scheduler #(
    parameter int N_SENS         = 4,
    parameter int GAP_CYCLES     = 6000000,
    parameter int TIMEOUT_CYCLES = 4000000
) (
    input logic               clk,
    input logic               rst,
    hcsr04_scheduler_if.slave bus
);
    localparam int SW = $clog2(N_SENS);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
    // cnt reads 0 in the first WAIT cycle, one behind the start pulse, so the gap closes one count early
    localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 2);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sel_q, sel_d, last_q, last_d, res_id_q, res_id_d, nxt, cand;
    logic [31:0]   cnt_q, cnt_d, cnt_inc;
    logic [11:0]   res_dist_q, res_dist_d;
    logic          res_valid_q, res_valid_d, res_err_q, res_err_d;
    logic          eng_rst_n_q, eng_rst_n_d, eng_start_q, eng_start_d, busy_q, busy_d;
    logic          go;

    // scan downwards so the nearest enabled index after last wins; last itself is the final candidate
    always_comb begin
        nxt  = last_q;
        cand = last_q;
        for (int k = N_SENS; k >= 1; k--) begin
            cand = SW'((int'(last_q) + k) % N_SENS);
            if (bus.en_mask[cand]) nxt = cand;
        end
    end

    assign go      = bus.run && (|bus.en_mask);
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 32'd1;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        res_dist_d  = res_dist_q;
        res_err_d   = res_err_q;
        eng_rst_n_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                state_d = go ? S_START : S_IDLE;
                sel_d   = go ? nxt : sel_q;
            end
            S_START: begin
                last_d  = sel_q;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (bus.eng_val || cnt_q == TO_LAST) begin
                    state_d     = S_GAP;
                    res_valid_d = 1'b1;
                    res_id_d    = sel_q;
                    res_dist_d  = bus.eng_val ? bus.eng_distance : 12'd0;
                    res_err_d   = !bus.eng_val;
                    eng_rst_n_d = bus.eng_val;
                end
            end
            default: begin
                cnt_d = cnt_inc;
                if (cnt_q >= GAP_LAST) begin
                    state_d = go ? S_START : S_IDLE;
                    sel_d   = go ? nxt : sel_q;
                end
            end
        endcase
        eng_start_d = state_d == S_START;
        busy_d      = state_d != S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            last_q      <= SW'(N_SENS - 1);
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_dist_q  <= '0;
            res_err_q   <= 1'b0;
            eng_rst_n_q <= 1'b1;
            eng_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_dist_q  <= res_dist_d;
            res_err_q   <= res_err_d;
            eng_rst_n_q <= eng_rst_n_d;
            eng_start_q <= eng_start_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.busy      = busy_q;
    assign bus.eng_start = eng_start_q;
    assign bus.eng_rst_n = eng_rst_n_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_dist  = res_dist_q;
    assign bus.res_err   = res_err_q;
    assign bus.eng_echo  = bus.echo_in[sel_q];
    assign bus.trig_out  = bus.eng_trig ? (N_SENS'(1) << sel_q) : '0;
endmodule
